// File: rtl/conv_window_gen_if.sv
// Pixel-stream / window bus for the 3x3 window generator.
// The master drives pixels and the frame clear; the slave returns windows.
interface conv_window_gen_if #(
  parameter int DW = 8
);
  logic          frame_clr;
  logic          pix_valid;
  logic [DW-1:0] pix_in;
  logic          win_valid;
  logic          frame_done;
  logic [DW-1:0] win_1, win_2, win_3;
  logic [DW-1:0] win_4, win_5, win_6;
  logic [DW-1:0] win_7, win_8, win_9;

  modport master (
    output frame_clr, pix_valid, pix_in,
    input  win_valid, frame_done,
    input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
  );

  modport slave (
    input  frame_clr, pix_valid, pix_in,
    output win_valid, frame_done,
    output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
  );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous two rows; each accepted pixel shifts a
// new right column into the window. Windows are emitted for the valid region
// only (row >= 2, col >= 2), one cycle after the completing pixel.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input logic               clk,
  input logic               rst,
  conv_window_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          win_valid_q;
  logic          frame_done_q;
  logic [DW-1:0] win_q [9];

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2; never reset.
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];

  logic accept;
  logic last_col;
  logic last_row;

  // Clear takes priority over a pixel presented in the same cycle.
  always_comb begin
    accept   = bus.pix_valid && !bus.frame_clr;
    last_col = (col_q == CW'(IMG_W - 1));
    last_row = (row_q == RW'(IMG_H - 1));
  end

  // Line-buffer update: old lb0 entry ages into lb1, new pixel into lb0.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus.pix_in;
    end
  end

  // Counters, window shift register and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.frame_clr) begin
        col_q <= '0;
        row_q <= '0;
      end else if (bus.pix_valid) begin
        // Shift columns left; new right column comes from lb1, lb0, pixel.
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_q[col_q];
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_q[col_q];
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bus.pix_in;

        win_valid_q <= (row_q >= RW'(2)) && (col_q >= CW'(2));

        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q        <= '0;
            frame_done_q <= 1'b1;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_1      = win_q[0];
  assign bus.win_2      = win_q[1];
  assign bus.win_3      = win_q[2];
  assign bus.win_4      = win_q[3];
  assign bus.win_5      = win_q[4];
  assign bus.win_6      = win_q[5];
  assign bus.win_7      = win_q[6];
  assign bus.win_8      = win_q[7];
  assign bus.win_9      = win_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a 4x4 image.
module tb_conv_window_gen;

  logic clk;
  logic rst;

  conv_window_gen_if #(.DW(8)) bus ();

  conv_window_gen #(
    .IMG_W (4),
    .IMG_H (4),
    .DW    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int nwin;
  int ndone;
  logic [71:0] wins     [16];
  int          win_cyc  [16];
  int          done_cyc [4];
  logic [71:0] held;

  function automatic logic [71:0] cur_win();
    return {bus.win_1, bus.win_2, bus.win_3,
            bus.win_4, bus.win_5, bus.win_6,
            bus.win_7, bus.win_8, bus.win_9};
  endfunction

  // Expected 4-wide-image window whose top-left pixel value is t.
  function automatic logic [71:0] w9(input int t);
    return {8'(t),     8'(t + 1), 8'(t + 2),
            8'(t + 4), 8'(t + 5), 8'(t + 6),
            8'(t + 8), 8'(t + 9), 8'(t + 10)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    cyc   = 0;
    nwin  = 0;
    ndone = 0;
  endtask

  // One clock: present inputs, sample outputs #1 after the edge.
  task automatic step(input logic v, input logic [7:0] p, input logic clr);
    bus.pix_valid = v;
    bus.pix_in    = p;
    bus.frame_clr = clr;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.frame_clr = 1'b0;
    cyc++;
    if (bus.win_valid === 1'b1) begin
      if (nwin < 16) begin
        wins[nwin]    = cur_win();
        win_cyc[nwin] = cyc;
      end
      nwin++;
    end
    if (bus.frame_done === 1'b1) begin
      if (ndone < 4) done_cyc[ndone] = cyc;
      ndone++;
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int p = first; p <= last; p++) step(1'b1, 8'(p), 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.frame_clr = 1'b0;
    clear_log();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_valid", 72'(bus.win_valid), 72'(0));
    chk("rst_frame_done", 72'(bus.frame_done), 72'(0));
    chk("rst_window", cur_win(), 72'(0));
    rst = 1'b0;

    // 1: continuous frame 1..16
    clear_log();
    send_range(1, 16);
    chk("s1_nwin", 72'(nwin), 72'(4));
    chk("s1_w0", wins[0], w9(1));
    chk("s1_w1", wins[1], w9(2));
    chk("s1_w2", wins[2], w9(5));
    chk("s1_w3", wins[3], w9(6));
    chk("s1_w0_cyc", 72'(win_cyc[0]), 72'(11));
    chk("s1_w3_cyc", 72'(win_cyc[3]), 72'(16));
    chk("s1_ndone", 72'(ndone), 72'(1));
    chk("s1_done_cyc", 72'(done_cyc[0]), 72'(16));

    // 2: pixel every other cycle; outputs hold during gaps
    clear_log();
    for (int p = 1; p <= 16; p++) begin
      step(1'b1, 8'(p), 1'b0);
      held = cur_win();
      step(1'b0, 8'hEE, 1'b0);
      if (p == 11 || p == 16) begin
        chk("s2_gap_valid", 72'(bus.win_valid), 72'(0));
        chk("s2_gap_hold", cur_win(), held);
      end
    end
    chk("s2_nwin", 72'(nwin), 72'(4));
    chk("s2_w0", wins[0], w9(1));
    chk("s2_w1", wins[1], w9(2));
    chk("s2_w2", wins[2], w9(5));
    chk("s2_w3", wins[3], w9(6));
    chk("s2_w0_cyc", 72'(win_cyc[0]), 72'(21));
    chk("s2_w2_cyc", 72'(win_cyc[2]), 72'(29));
    chk("s2_done_cyc", 72'(done_cyc[0]), 72'(31));

    // 3: back-to-back frames 1..16, 17..32
    clear_log();
    send_range(1, 32);
    chk("s3_nwin", 72'(nwin), 72'(8));
    chk("s3_w4", wins[4], w9(17));
    chk("s3_w7", wins[7], w9(22));
    chk("s3_w4_cyc", 72'(win_cyc[4]), 72'(27));
    chk("s3_ndone", 72'(ndone), 72'(2));
    chk("s3_done0_cyc", 72'(done_cyc[0]), 72'(16));
    chk("s3_done1_cyc", 72'(done_cyc[1]), 72'(32));

    // 4: reset mid-frame abandons the partial frame
    clear_log();
    send_range(1, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    send_range(101, 116);
    chk("s4_nwin", 72'(nwin), 72'(4));
    chk("s4_w0", wins[0], w9(101));
    chk("s4_w3", wins[3], w9(106));
    chk("s4_ndone", 72'(ndone), 72'(1));

    // 5: frame_clr wins over a simultaneous pixel
    clear_log();
    send_range(1, 10);
    step(1'b1, 8'd99, 1'b1);
    chk("s5_clr_nwin", 72'(nwin), 72'(0));
    clear_log();
    send_range(1, 16);
    chk("s5_nwin", 72'(nwin), 72'(4));
    chk("s5_w0", wins[0], w9(1));
    chk("s5_w1", wins[1], w9(2));
    chk("s5_w2", wins[2], w9(5));
    chk("s5_w3", wins[3], w9(6));
    chk("s5_done_cyc", 72'(done_cyc[0]), 72'(16));

    // 6: asynchronous reset clears outputs before the next edge
    clear_log();
    send_range(1, 16);
    chk("s6_pre_valid", 72'(bus.win_valid), 72'(1));
    chk("s6_pre_done", 72'(bus.frame_done), 72'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", 72'(bus.win_valid), 72'(0));
    chk("s6_async_done", 72'(bus.frame_done), 72'(0));
    chk("s6_async_window", cur_win(), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
